mix_columns_iter: RTL and testbench
===================================

Name: mix_columns_iter

Overview:
- AES MixColumns stage that sits directly downstream of the ShiftRows register stage and consumes its 16 output bytes.
- Processes the 4x4 state iteratively, COLS_PER_CYCLE columns per clock, to trade latency for GF(2^8) multiplier area.
- Uses a start/busy/done handshake toward the round controller.
- Provides a bypass for the final AES round, where MixColumns is skipped.

Parameters:
COLS_PER_CYCLE, 1, columns mixed per clock; legal values 1, 2, 4; any other value is an elaboration error.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request to process state_in; sampled only in IDLE
bypass  input  1  sampled with start; 1 means pass state_in through unmixed (final round)
state_in  input  128  ShiftRows output; byte Bk = state_in[127-8k -: 8]; column c = {B(4c), B(4c+1), B(4c+2), B(4c+3)}, with row 0 first
state_out  output  128  mixed state, same byte mapping; registered
busy  output  1  high from the accept edge until the completion edge
done  output  1  one-cycle pulse; state_out is valid from this cycle on

Behaviour:
- Reset (rst low, asynchronous): state_out=0, busy=0, done=0, column counter=0, working register=0, FSM=IDLE.
- FSM states: IDLE, MIX.
- IDLE with start=1 at edge T:
  - Load state_in into the working register and latch bypass.
  - Set busy=1.
  - If bypass=1, go to MIX with the counter preset to the final step.
- MIX, N = 4/COLS_PER_CYCLE:
  - Each edge replaces the next COLS_PER_CYCLE columns of the working register with their mixed values, in column order 0,1,2,3.
  - On edge T+N:
    - state_out <= complete result.
    - busy <= 0, done <= 1, FSM returns to IDLE.
  - done is high for exactly the one cycle after edge T+N.
- Bypass:
  - On edge T+1, state_out <= captured state_in unchanged; busy <= 0; done <= 1.
  - Latency is 1 regardless of COLS_PER_CYCLE.
- Column mix for (a0,a1,a2,a3):
  - r0 = 2a0^3a1^a2^a3
  - r1 = a0^2a1^3a2^a3
  - r2 = a0^a1^2a2^3a3
  - r3 = 3a0^a1^a2^2a3
  - xtime(b) = {b[6:0],0} ^ (b[7] ? 8'h1B : 8'h00); 3b = xtime(b)^b. All arithmetic is 8-bit with no carries.
- state_out only changes on a completion edge or on reset. It holds its last value between operations and during busy.
- Simultaneous events:
  - start while busy=1 is ignored; there is no queueing and no error.
  - start in the same cycle done=1 is accepted, since the FSM is already in IDLE; back-to-back throughput is one operation per N+1 cycles.
  - state_in and bypass are don't-care except on the accept edge.
- Reset mid-operation: the operation is aborted, all outputs return to their reset values, and no done pulse is produced.

Test Plan:
- Reset: hold rst low 3 cycles with start=1 -> state_out=0, busy=0, done=0. Release; start stays low -> no activity.
- FIPS-197 columns, COLS_PER_CYCLE=1, bypass=0:
  - Stimulus: col0 db135345, col1 f20a225c, col2 01010101, col3 2d26314c.
  - Required: state_out = 8e4da1bc 9fdc589d 01010101 4d7ebdf8.
  - Timing: busy high for exactly 4 cycles; done pulses once, on the 5th cycle after the accept edge.
- Same vector at COLS_PER_CYCLE=2 and 4 -> identical state_out; done 3 and 2 cycles after the accept edge respectively.
- Bypass: start=1, bypass=1, state_in=00112233445566778899aabbccddeeff -> state_out equal to state_in, done one cycle after accept.
- Handshake edges:
  - start pulsed during busy -> ignored; the first result is unaffected.
  - start held high continuously -> a new operation is accepted in every done cycle.
  - Column c6c6c6c6 -> c6c6c6c6; column d4d4d4d5 -> d5d5d7d6.
- Abort: assert rst low 2 cycles after start -> outputs zero immediately (asynchronously), no done. A fresh start afterwards completes normally with the correct result.

Source files
------------

// File: rtl/mix_columns_iter.sv
// AES MixColumns stage that mixes COLS_PER_CYCLE columns per clock.
// A start/busy/done handshake faces the round controller. A bypass path
// serves the final round, where the state passes through unmixed.
module mix_columns_iter #(
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         bypass,
   input  logic [127:0] state_in,
   output logic [127:0] state_out,
   output logic         busy,
   output logic         done
);

   localparam int unsigned STATE_W  = 128;
   localparam int unsigned COL_W    = 32;
   localparam int unsigned NUM_COLS = 4;
   localparam int unsigned CNT_W    = 2;
   localparam int unsigned N_STEPS  = NUM_COLS / COLS_PER_CYCLE;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_STEPS - 1);

   // Only a whole number of steps that divides the four columns is supported
   generate
      if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
         $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MIX  = 1'b1
   } state_t;

   // Multiply by x in GF(2^8) with the AES reduction polynomial
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   // Mix one column; row 0 sits in the most significant byte
   function automatic logic [COL_W-1:0] mix_col(input logic [COL_W-1:0] c);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] r0, r1, r2, r3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      r0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
      r1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
      r2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
      r3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
      return {r0, r1, r2, r3};
   endfunction

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 w_accept;
   logic                 w_step;
   logic                 w_finish;

   logic [CNT_W-1:0]     r_cnt;
   logic [STATE_W-1:0]   r_work;
   logic                 r_bypass;
   logic [STATE_W-1:0]   r_state_out;
   logic                 r_busy;
   logic                 r_done;

   logic [6:0]           w_col_lsb;
   logic [STATE_W-1:0]   w_work_mixed;
   logic [STATE_W-1:0]   w_result;

   assign state_out = r_state_out;
   assign busy      = r_busy;
   assign done      = r_done;

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and control strobes
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_MIX;
            end
         end
         ST_MIX: begin
            w_step = 1'b1;
            if (r_cnt == LAST_STEP) begin
               w_finish    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Replace the columns owned by the current step with their mixed values
   always_comb begin
      w_work_mixed = r_work;
      w_col_lsb    = 7'd0;
      for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
         w_col_lsb = 7'((NUM_COLS - 1 - (32'(r_cnt) * COLS_PER_CYCLE + j)) * COL_W);
         w_work_mixed[w_col_lsb +: COL_W] = mix_col(r_work[w_col_lsb +: COL_W]);
      end
   end

   // Final-round operations skip the mixing entirely
   assign w_result = r_bypass ? r_work : w_work_mixed;

   // Working register, step counter and registered handshake outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt       <= '0;
         r_work      <= '0;
         r_bypass    <= 1'b0;
         r_state_out <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_work   <= state_in;
            r_bypass <= bypass;
            r_busy   <= 1'b1;
            r_cnt    <= bypass ? LAST_STEP : '0;
         end else if (w_step) begin
            r_work <= w_result;
            if (w_finish) begin
               r_cnt       <= '0;
               r_state_out <= w_result;
               r_busy      <= 1'b0;
               r_done      <= 1'b1;
            end else begin
               r_cnt <= CNT_W'(r_cnt + 2'd1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed bench for mix_columns_iter at 1, 2 and 4 columns per cycle.
module tb_mix_columns_iter;

   localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
   localparam logic [127:0] FIPS_EXP = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
   localparam logic [127:0] BYP_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;
   localparam logic [127:0] EDGE_IN  = 128'hc6c6c6c6_d4d4d4d5_db135345_01010101;
   localparam logic [127:0] EDGE_EXP = 128'hc6c6c6c6_d5d5d7d6_8e4da1bc_01010101;
   localparam logic [127:0] GARBAGE  = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         bypass;
   logic [127:0] state_in;
   logic [127:0] so [3];
   logic         busy [3];
   logic         done [3];

   int           n_chk = 0;
   int           n_err = 0;
   int           op = 0;
   int           nn [3] = '{4, 2, 1};
   logic [127:0] prev [3];

   always #5 clk = ~clk;

   mix_columns_iter #(.COLS_PER_CYCLE(1)) u_c1 (
      .clk(clk), .rst(rst), .start(start), .bypass(bypass), .state_in(state_in),
      .state_out(so[0]), .busy(busy[0]), .done(done[0]));
   mix_columns_iter #(.COLS_PER_CYCLE(2)) u_c2 (
      .clk(clk), .rst(rst), .start(start), .bypass(bypass), .state_in(state_in),
      .state_out(so[1]), .busy(busy[1]), .done(done[1]));
   mix_columns_iter #(.COLS_PER_CYCLE(4)) u_c4 (
      .clk(clk), .rst(rst), .start(start), .bypass(bypass), .state_in(state_in),
      .state_out(so[2]), .busy(busy[2]), .done(done[2]));

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s dut%0d state_out", tag, i), so[i], 128'h0);
         chk($sformatf("%s dut%0d busy", tag, i), 128'(busy[i]), 128'h0);
         chk($sformatf("%s dut%0d done", tag, i), 128'(done[i]), 128'h0);
      end
   endtask

   // One operation from an idle negedge; optionally pulse start while busy
   task automatic run_op(input logic [127:0] din, input logic byp,
                         input logic [127:0] dexp, input bit pulse);
      int n;
      op++;
      start    = 1'b1;
      bypass   = byp;
      state_in = din;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            n = byp ? 1 : nn[i];
            chk($sformatf("op%0d k%0d dut%0d done", op, k, i), 128'(done[i]),
                128'(k == n + 1));
            chk($sformatf("op%0d k%0d dut%0d busy", op, k, i), 128'(busy[i]),
                128'(k <= n));
            chk($sformatf("op%0d k%0d dut%0d state_out", op, k, i), so[i],
                (k >= n + 1) ? dexp : prev[i]);
         end
         if (k == 1 && pulse) begin
            start    = 1'b1;
            bypass   = 1'b1;
            state_in = GARBAGE;
         end else begin
            start    = 1'b0;
            bypass   = 1'b0;
            state_in = '0;
         end
      end
      for (int i = 0; i < 3; i++) prev[i] = dexp;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with start asserted
      rst      = 1'b0;
      start    = 1'b1;
      bypass   = 1'b0;
      state_in = FIPS_IN;
      for (int i = 0; i < 3; i++) prev[i] = '0;
      repeat (3) begin
         @(negedge clk);
         chk_zero("reset");
      end
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk_zero("idle");
      end

      run_op(FIPS_IN, 1'b0, FIPS_EXP, 1'b0);
      run_op(BYP_IN, 1'b1, BYP_IN, 1'b0);
      run_op(EDGE_IN, 1'b0, EDGE_EXP, 1'b0);
      run_op(FIPS_IN, 1'b0, FIPS_EXP, 1'b1);

      // Start held high: every done cycle also accepts a new operation
      start    = 1'b1;
      bypass   = 1'b0;
      state_in = EDGE_IN;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("held k%0d dut%0d done", k, i), 128'(done[i]),
                128'(k % (nn[i] + 1) == 0));
            chk($sformatf("held k%0d dut%0d busy", k, i), 128'(busy[i]),
                128'(k % (nn[i] + 1) != 0));
            if (k % (nn[i] + 1) == 0)
               chk($sformatf("held k%0d dut%0d state_out", k, i), so[i], EDGE_EXP);
         end
      end
      start = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < 3; i++) prev[i] = EDGE_EXP;

      // Abort two cycles into an operation
      start    = 1'b1;
      state_in = FIPS_IN;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst = 1'b0;
      #1 chk_zero("abort async");
      @(negedge clk);
      chk_zero("abort hold1");
      @(negedge clk);
      chk_zero("abort hold2");
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk_zero("abort after");
      end
      for (int i = 0; i < 3; i++) prev[i] = '0;
      run_op(EDGE_IN, 1'b0, EDGE_EXP, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
